// File: rtl/button_events.sv
// button_events: converts debounced button levels into SHORT/LONG/REPEAT events
// and queues them through a small FIFO with a valid/ready handshake.
module button_events #(
    parameter int num          = 2,
    parameter int tick_div     = 1048576,
    parameter int long_ticks   = 48,
    parameter int repeat_ticks = 10,
    parameter int fifo_depth   = 4,
    localparam int bw = (num > 1) ? $clog2(num) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [num-1:0] buttons_in,
    output logic          event_valid,
    input  logic          event_ready,
    output logic [bw-1:0] event_button,
    output logic [1:0]    event_kind,
    output logic          overflow,
    input  logic          overflow_clear
);
    localparam int cw = $clog2(((long_ticks > repeat_ticks) ? long_ticks : repeat_ticks) + 1);
    localparam int dw = $clog2(tick_div);
    localparam int aw = $clog2(fifo_depth);
    localparam logic [cw-1:0] c_long = cw'(long_ticks);
    localparam logic [cw-1:0] c_rep  = cw'(repeat_ticks);
    localparam logic [dw-1:0] c_div  = dw'(tick_div - 1);
    localparam logic [1:0] k_short = 2'd0;
    localparam logic [1:0] k_long  = 2'd1;
    localparam logic [1:0] k_rep   = 2'd2;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    logic [dw-1:0]  r_div;
    logic           w_tick;
    logic [num-1:0] r_prev;
    state_t         r_state [num];
    state_t         w_state_nx [num];
    logic [cw-1:0]  r_cnt [num];
    logic [cw-1:0]  w_cnt_nx [num];
    logic [cw-1:0]  w_inc [num];
    logic [num-1:0] w_emit;
    logic [1:0]     w_emit_kind [num];
    logic [num-1:0] r_pend_v;
    logic [1:0]     r_pend_k [num];
    logic [num-1:0] w_grant;
    logic [num-1:0] w_occ;
    logic [bw-1:0]  w_sel;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_drop;
    logic [bw-1:0]  r_mem_b [fifo_depth];
    logic [1:0]     r_mem_k [fifo_depth];
    logic [aw:0]    r_wp;
    logic [aw:0]    r_rp;
    logic           r_ovf;

    assign w_tick       = (r_div == c_div);
    assign w_full       = (r_wp[aw] != r_rp[aw]) && (r_wp[aw-1:0] == r_rp[aw-1:0]);
    assign event_valid  = (r_wp != r_rp);
    assign w_pop        = event_valid & event_ready;
    assign event_button = r_mem_b[r_rp[aw-1:0]];
    assign event_kind   = r_mem_k[r_rp[aw-1:0]];
    assign overflow     = r_ovf;
    // A slot being pushed this cycle is free again for a new event at the same edge.
    assign w_occ        = r_pend_v & ~w_grant;
    assign w_drop       = |(w_emit & w_occ);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_prev <= '1;
        end else begin
            r_div  <= w_tick ? '0 : r_div + dw'(1);
            r_prev <= buttons_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num; i++) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < num; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < num; i++) begin
            w_state_nx[i]  = r_state[i];
            w_cnt_nx[i]    = r_cnt[i];
            w_emit[i]      = 1'b0;
            w_emit_kind[i] = k_short;
            w_inc[i]       = r_cnt[i] + cw'(1);
            case (r_state[i])
                IDLE: begin
                    if (buttons_in[i] & ~r_prev[i]) begin
                        w_state_nx[i] = PRESSED;
                        w_cnt_nx[i]   = '0;
                    end
                end
                PRESSED: begin
                    if (!buttons_in[i]) begin
                        w_state_nx[i] = IDLE;
                        w_emit[i]     = 1'b1;
                    end else if (w_tick) begin
                        w_cnt_nx[i]    = (w_inc[i] == c_long) ? '0 : w_inc[i];
                        w_state_nx[i]  = (w_inc[i] == c_long) ? HELD : PRESSED;
                        w_emit[i]      = (w_inc[i] == c_long);
                        w_emit_kind[i] = k_long;
                    end
                end
                HELD: begin
                    if (!buttons_in[i]) begin
                        w_state_nx[i] = IDLE;
                    end else if (w_tick) begin
                        w_cnt_nx[i]    = (w_inc[i] == c_rep) ? '0 : w_inc[i];
                        w_emit[i]      = (w_inc[i] == c_rep);
                        w_emit_kind[i] = k_rep;
                    end
                end
                default: w_state_nx[i] = IDLE;
            endcase
        end
    end

    // Lowest-index occupied slot wins; the fullness test uses start-of-cycle pointers.
    always_comb begin
        w_sel = '0;
        for (int i = num - 1; i >= 0; i--)
            if (r_pend_v[i]) w_sel = bw'(i);
        w_push = (|r_pend_v) & ~w_full;
        for (int i = 0; i < num; i++)
            w_grant[i] = w_push & (w_sel == bw'(i));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_v <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < num; i++) r_pend_k[i] <= k_short;
            for (int i = 0; i < fifo_depth; i++) begin
                r_mem_b[i] <= '0;
                r_mem_k[i] <= k_short;
            end
        end else begin
            for (int i = 0; i < num; i++) begin
                if (w_emit[i] & ~w_occ[i]) begin
                    r_pend_v[i] <= 1'b1;
                    r_pend_k[i] <= w_emit_kind[i];
                end else if (w_grant[i]) begin
                    r_pend_v[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_mem_b[r_wp[aw-1:0]] <= w_sel;
                r_mem_k[r_wp[aw-1:0]] <= r_pend_k[w_sel];
                r_wp <= r_wp + (aw+1)'(1);
            end
            if (w_pop) r_rp <= r_rp + (aw+1)'(1);
            r_ovf <= w_drop ? 1'b1 : (overflow_clear ? 1'b0 : r_ovf);
        end
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: scoreboard bench; stimulus queues expected events, a monitor
// pops and compares them on every accepted handshake.
module tb_button_events;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] buttons = 2'b00;
    logic       ready = 1'b1;
    logic       ovf_clr = 1'b0;
    logic       ev_valid;
    logic       ev_button;
    logic [1:0] ev_kind;
    logic       ovf;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         exp_q[$];
    int         seen_t[$];
    int         c;
    int         r;

    button_events #(
        .num(2), .tick_div(4), .long_ticks(3), .repeat_ticks(2), .fifo_depth(2)
    ) dut (
        .clock(clk),
        .reset(rst),
        .buttons_in(buttons),
        .event_valid(ev_valid),
        .event_ready(ready),
        .event_button(ev_button),
        .event_kind(ev_kind),
        .overflow(ovf),
        .overflow_clear(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ev_valid && ready) begin
            seen_t.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_event", int'(ev_button) * 4 + int'(ev_kind), -1);
            else check("event", int'(ev_button) * 4 + int'(ev_kind), exp_q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse(input int b);
        buttons[b] = 1'b1;
        step(1);
        buttons[b] = 1'b0;
        step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        step(2);
        check("rst_valid", ev_valid, 0);
        check("rst_button", ev_button, 0);
        check("rst_kind", ev_kind, 0);
        check("rst_overflow", ovf, 0);
        rst = 1'b0;
        // 1: short press of button 0
        do_reset();
        seen_t.delete();
        step(2);
        buttons[0] = 1'b1;
        exp_q.push_back(0 * 4 + 0);
        step(5);
        buttons[0] = 1'b0;
        r = cyc;
        step(8);
        check("t1_count", seen_t.size(), 1);
        if (seen_t.size() > 0) check("t1_latency", seen_t[0] - r, 2);
        // 2: long hold of button 1, LONG then REPEATs, nothing on release
        do_reset();
        seen_t.delete();
        step(2);
        c = cyc;
        buttons[1] = 1'b1;
        exp_q.push_back(1 * 4 + 1);
        repeat (3) exp_q.push_back(1 * 4 + 2);
        step(40);
        buttons[1] = 1'b0;
        step(10);
        check("t2_count", seen_t.size(), 4);
        if (seen_t.size() == 4) begin
            check("t2_long_time", seen_t[0] - c, 11);
            check("t2_rep1_gap", seen_t[1] - seen_t[0], 8);
            check("t2_rep2_gap", seen_t[2] - seen_t[1], 8);
            check("t2_rep3_gap", seen_t[3] - seen_t[2], 8);
        end
        // 3: simultaneous presses drain in index order on consecutive cycles
        do_reset();
        seen_t.delete();
        step(2);
        buttons = 2'b11;
        exp_q.push_back(0 * 4 + 0);
        exp_q.push_back(1 * 4 + 0);
        step(3);
        buttons = 2'b00;
        r = cyc;
        step(8);
        check("t3_count", seen_t.size(), 2);
        if (seen_t.size() == 2) begin
            check("t3_first_time", seen_t[0] - r, 2);
            check("t3_second_time", seen_t[1] - r, 3);
        end
        // 4: stalled consumer, FIFO and slots fill, fifth event overflows
        do_reset();
        seen_t.delete();
        ready = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) begin
            pulse(i % 2);
            exp_q.push_back((i % 2) * 4 + 0);
        end
        check("t4_ovf_before", ovf, 0);
        check("t4_head_valid", ev_valid, 1);
        check("t4_head_button", ev_button, 0);
        pulse(0);
        check("t4_ovf_set", ovf, 1);
        ready = 1'b1;
        step(10);
        check("t4_drained", seen_t.size(), 4);
        check("t4_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", ovf, 0);
        // 5: button held through reset release gives no event until re-pressed
        buttons[0] = 1'b1;
        do_reset();
        seen_t.delete();
        step(20);
        check("t5_held_silent", seen_t.size(), 0);
        buttons[0] = 1'b0;
        step(2);
        buttons[0] = 1'b1;
        exp_q.push_back(0 * 4 + 0);
        step(3);
        buttons[0] = 1'b0;
        r = cyc;
        step(6);
        check("t5_count", seen_t.size(), 1);
        if (seen_t.size() > 0) check("t5_latency", seen_t[0] - r, 2);
        // 6: reset while HELD with LONG queued discards everything
        do_reset();
        seen_t.delete();
        ready = 1'b0;
        step(2);
        buttons[1] = 1'b1;
        step(12);
        check("t6_queued_valid", ev_valid, 1);
        check("t6_queued_kind", ev_kind, 1);
        check("t6_queued_button", ev_button, 1);
        rst = 1'b1;
        #1;
        check("t6_async_valid", ev_valid, 0);
        step(2);
        rst = 1'b0;
        ready = 1'b1;
        step(20);
        buttons[1] = 1'b0;
        step(5);
        check("t6_no_stale", seen_t.size(), 0);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
